// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//            The result is computed at launch and committed to HI/LO after a
//            fixed latency. MTHI/MTLO write HI/LO directly when idle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  // Arithmetic datapath: products and quotients from the current operands
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    // A zero divisor never commits; substitute 1 so the divider stays defined
    b_safe = (b == 32'd0) ? 32'd1 : b;
    // Signed division via magnitudes; 0x80000000 / -1 wraps back to 0x80000000
    a_mag  = a[31] ? (32'd0 - a) : a;
    b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    quo_s  = (a[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
    rem_s  = a[31] ? (32'd0 - r_mag) : r_mag;
    quo_u  = a / b_safe;
    rem_u  = a % b_safe;
  end

  // Next-state logic: launch when idle, count down and commit when running
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (cnt_q == '0) begin
      if (start) begin
        case (op)
          OP_MULT: begin
            {pend_hi_d, pend_lo_d} = prod_s;
            cnt_d     = C_MULT_CNT;
            pend_we_d = 1'b1;
          end
          OP_MULTU: begin
            {pend_hi_d, pend_lo_d} = prod_u;
            cnt_d     = C_MULT_CNT;
            pend_we_d = 1'b1;
          end
          OP_DIV: begin
            pend_lo_d = quo_s;
            pend_hi_d = rem_s;
            cnt_d     = C_DIV_CNT;
            pend_we_d = (b != 32'd0);
          end
          OP_DIVU: begin
            pend_lo_d = quo_u;
            pend_hi_d = rem_u;
            cnt_d     = C_DIV_CNT;
            pend_we_d = (b != 32'd0);
          end
          OP_MTHI: hi_d = a;
          OP_MTLO: lo_d = a;
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - C_CNT_ONE;
      if ((cnt_q == C_CNT_ONE) && pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
    busy_d = (cnt_d != '0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
